// File: rtl/plot_port_arbiter.sv
// plot_port_arbiter: shares the single VGA framebuffer write port among
// N_REQ plot-stream engines. Grants use a req/grant handshake. Selection is
// round-robin or fixed priority, and long bursts can optionally be preempted.
// Grant, pixel and busy outputs are registered. out_pause holds the char
// stream while any engine requests or draws.
module plot_port_arbiter #(
    parameter int N_REQ     = 4,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOR_W   = 3,
    parameter int MAX_BURST = 0,
    parameter int RR_MODE   = 1
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           req_plot,
    input  logic [N_REQ*X_W-1:0]       req_x,
    input  logic [N_REQ*Y_W-1:0]       req_y,
    input  logic [N_REQ*COLOR_W-1:0]   req_color,
    output logic [N_REQ-1:0]           grant,
    output logic [X_W-1:0]             out_x,
    output logic [Y_W-1:0]             out_y,
    output logic [COLOR_W-1:0]         out_color,
    output logic                       plot,
    output logic                       out_pause,
    output logic                       busy
);

    localparam int IDX_W = (N_REQ < 2) ? 1 : $clog2(N_REQ);
    localparam int CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t                         state, state_d;
    logic [IDX_W-1:0]               gnt_idx, gnt_idx_d;
    logic [IDX_W-1:0]               rr_ptr, rr_ptr_d;
    logic [CNT_W-1:0]               burst_cnt, burst_cnt_d;
    logic [N_REQ-1:0]               grant_d;
    logic                           plot_d, busy_d;
    logic [X_W-1:0]                 out_x_d;
    logic [Y_W-1:0]                 out_y_d;
    logic [COLOR_W-1:0]             out_color_d;
    logic [IDX_W-1:0]               win;
    logic                           others_pending;

    // Per-lane views of the packed request buses.
    logic [N_REQ-1:0][X_W-1:0]      lane_x;
    logic [N_REQ-1:0][Y_W-1:0]      lane_y;
    logic [N_REQ-1:0][COLOR_W-1:0]  lane_c;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane_x[i] = req_x[i*X_W +: X_W];
        assign lane_y[i] = req_y[i*Y_W +: Y_W];
        assign lane_c[i] = req_color[i*COLOR_W +: COLOR_W];
    end

    // Char stream holds as soon as anyone asks, and until the port goes idle.
    assign out_pause = (|req) | busy;

    // Another requester is waiting besides the granted one.
    assign others_pending = |(req & ~grant);

    // Winner select. Scan downward so the closest candidate is written last and wins.
    always_comb begin
        win = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int c;
            if (RR_MODE != 0) begin
                c = int'(rr_ptr) + k;
                if (c >= N_REQ) c = c - N_REQ;
            end else begin
                c = k;
            end
            if (req[c]) win = IDX_W'(c);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state;
        gnt_idx_d   = gnt_idx;
        rr_ptr_d    = rr_ptr;
        burst_cnt_d = burst_cnt;
        grant_d     = grant;
        plot_d      = 1'b0;
        out_x_d     = out_x;
        out_y_d     = out_y;
        out_color_d = out_color;

        case (state)
            IDLE, GAP: begin
                grant_d = '0;
                if (|req) begin
                    state_d       = GRANT;
                    gnt_idx_d     = win;
                    grant_d[win]  = 1'b1;
                    burst_cnt_d   = '0;
                    if (RR_MODE != 0)
                        rr_ptr_d = (win == LAST_IDX) ? '0 : win + 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    // A drop wins over a coincident preemption; no pixel is taken.
                    grant_d = '0;
                    state_d = GAP;
                end else begin
                    // The requester saw grant this cycle, so its strobe counts even if preempted.
                    plot_d = req_plot[gnt_idx];
                    if (req_plot[gnt_idx]) begin
                        out_x_d     = lane_x[gnt_idx];
                        out_y_d     = lane_y[gnt_idx];
                        out_color_d = lane_c[gnt_idx];
                    end
                    if (MAX_BURST != 0 && burst_cnt == BURST_LAST && others_pending) begin
                        grant_d = '0;
                        state_d = GAP;
                    end else if (burst_cnt != CNT_MAX) begin
                        burst_cnt_d = burst_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset clears everything at once, mid-burst included.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant     <= '0;
            plot      <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_color <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            gnt_idx   <= gnt_idx_d;
            rr_ptr    <= rr_ptr_d;
            burst_cnt <= burst_cnt_d;
            grant     <= grant_d;
            plot      <= plot_d;
            out_x     <= out_x_d;
            out_y     <= out_y_d;
            out_color <= out_color_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Bench for plot_port_arbiter. It drives three instances from one shared
// stimulus: round-robin, fixed-priority and round-robin with MAX_BURST=4.
// Expected values come from directed tables and from a requester model.
module tb_plot_port_arbiter;

    localparam int N = 4;

    logic              clock  = 1'b0;
    logic              resetn = 1'b1;
    logic [N-1:0]      req, req_plot;
    logic [N*8-1:0]    req_x;
    logic [N*7-1:0]    req_y;
    logic [N*3-1:0]    req_color;

    logic [N-1:0]      grant_o [3];
    logic [7:0]        ox      [3];
    logic [6:0]        oy      [3];
    logic [2:0]        oc      [3];
    logic              plot_o  [3];
    logic              pause_o [3];
    logic              busy_o  [3];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    plot_port_arbiter #(.N_REQ(N), .X_W(8), .Y_W(7), .COLOR_W(3), .MAX_BURST(0), .RR_MODE(1)) dut_rr (
        .clock(clock), .resetn(resetn), .req(req), .req_plot(req_plot),
        .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .grant(grant_o[0]), .out_x(ox[0]), .out_y(oy[0]), .out_color(oc[0]),
        .plot(plot_o[0]), .out_pause(pause_o[0]), .busy(busy_o[0]));

    plot_port_arbiter #(.N_REQ(N), .X_W(8), .Y_W(7), .COLOR_W(3), .MAX_BURST(0), .RR_MODE(0)) dut_fx (
        .clock(clock), .resetn(resetn), .req(req), .req_plot(req_plot),
        .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .grant(grant_o[1]), .out_x(ox[1]), .out_y(oy[1]), .out_color(oc[1]),
        .plot(plot_o[1]), .out_pause(pause_o[1]), .busy(busy_o[1]));

    plot_port_arbiter #(.N_REQ(N), .X_W(8), .Y_W(7), .COLOR_W(3), .MAX_BURST(4), .RR_MODE(1)) dut_pb (
        .clock(clock), .resetn(resetn), .req(req), .req_plot(req_plot),
        .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .grant(grant_o[2]), .out_x(ox[2]), .out_y(oy[2]), .out_color(oc[2]),
        .plot(plot_o[2]), .out_pause(pause_o[2]), .busy(busy_o[2]));

    typedef struct {
        bit         rst;     // pulse reset before this row
        int         dut;     // 0 rr, 1 fixed, 2 preempt
        logic [3:0] rq;
        logic [3:0] rp;
        logic [3:0] eg;      // expected grant after the edge
        bit         ep;      // expected plot
        bit         eb;      // expected busy
        bit         co;      // check out_* against requester ei
        int         ei;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, int d, logic [3:0] rq, logic [3:0] rp,
                                logic [3:0] eg, bit ep, bit eb, bit co, int ei);
        vec_t v;
        v.rst = rst; v.dut = d; v.rq = rq; v.rp = rp; v.eg = eg;
        v.ep = ep; v.eb = eb; v.co = co; v.ei = ei;
        return v;
    endfunction

    function automatic logic [7:0] xi(int i); return 8'(5 + 16*i); endfunction
    function automatic logic [6:0] yi(int i); return 7'(9 + 16*i); endfunction
    function automatic logic [2:0] ci(int i); return 3'(3 + i);    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn   = 1'b0;
        req      = '0;
        req_plot = '0;
        @(negedge clock);
        resetn   = 1'b1;
    endtask

    task automatic set_coords();
        for (int i = 0; i < N; i++) begin
            req_x[i*8 +: 8]     = xi(i);
            req_y[i*7 +: 7]     = yi(i);
            req_color[i*3 +: 3] = ci(i);
        end
    endtask

    // State of the requester-0 stream model used by the preemption test.
    int   x0, exp_pix, r2pix;
    logic g0p;

    // One cycle of the preemption test. It checks pixel order and advances requester 0's stream.
    task automatic pb_step();
        @(negedge clock);
        if (plot_o[2]) begin
            if (ox[2] >= 8'd200) r2pix++;
            else begin
                chk("pb_pix_order", 32'(ox[2]), 32'(exp_pix));
                exp_pix++;
            end
        end
        if (g0p) x0++;
        g0p = grant_o[2][0];
        req_x[7:0] = 8'(x0);
    endtask

    initial begin
        int d;
        req = '0; req_plot = '0;
        set_coords();

        // Reset holds every output at zero while requests toggle.
        #1 resetn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req      = 4'($urandom);
            req_plot = 4'($urandom);
            @(posedge clock); #1;
            chk("rst_grant", 32'(grant_o[0]), 0);
            chk("rst_plot",  32'(plot_o[0]), 0);
            chk("rst_out",   {ox[0], 1'b0, oy[0], 5'd0, oc[0]}, 0);
            chk("rst_busy",  32'(busy_o[0]), 0);
            chk("rst_pause", 32'(pause_o[0]), 32'(|req));
            chk("rst_grant_pb", 32'(grant_o[2] | grant_o[1]), 0);
        end

        // Single burst.
        tbl.push_back(mk(1, 0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0001, 4'b1110, 4'b0001, 0, 1, 1, 0)); // foreign strobes ignored, out holds
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 0)); // drop -> gap
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0)); // idle
        // Round-robin with all requesters held and a drop/reassert ending each burst.
        tbl.push_back(mk(1, 0, 4'b1111, 4'b1111, 4'b0001, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 4'b0001, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'b1110, 4'b1111, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 4'b0010, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 4'b0010, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4'b1101, 4'b1111, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 4'b0100, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 4'b0100, 1, 1, 1, 2));
        tbl.push_back(mk(0, 0, 4'b1011, 4'b1111, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 4'b1000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 4'b1000, 1, 1, 1, 3));
        tbl.push_back(mk(0, 0, 4'b0111, 4'b1111, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 4'b0001, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
        // Fixed priority: requester 1 wins every burst, and requester 2 wins only once 1 is gone.
        tbl.push_back(mk(1, 1, 4'b0110, 4'b0110, 4'b0010, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0110, 4'b0110, 4'b0010, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 4'b0100, 4'b0110, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0110, 4'b0110, 4'b0010, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0110, 4'b0110, 4'b0010, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 4'b0100, 4'b0110, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, 4'b0100, 4'b0100, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, 4'b0100, 4'b0100, 1, 1, 1, 2));
        tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            req      = tbl[i].rq;
            req_plot = tbl[i].rp;
            @(negedge clock);
            d = tbl[i].dut;
            chk($sformatf("v%0d_grant", i), 32'(grant_o[d]), 32'(tbl[i].eg));
            chk($sformatf("v%0d_plot", i),  32'(plot_o[d]),  32'(tbl[i].ep));
            chk($sformatf("v%0d_busy", i),  32'(busy_o[d]),  32'(tbl[i].eb));
            chk($sformatf("v%0d_pause", i), 32'(pause_o[d]), 32'((|tbl[i].rq) | tbl[i].eb));
            if (tbl[i].co) begin
                chk($sformatf("v%0d_x", i), 32'(ox[d]), 32'(xi(tbl[i].ei)));
                chk($sformatf("v%0d_y", i), 32'(oy[d]), 32'(yi(tbl[i].ei)));
                chk($sformatf("v%0d_c", i), 32'(oc[d]), 32'(ci(tbl[i].ei)));
            end
        end

        // Preemption after 4 granted cycles, with no requester-0 pixel lost.
        do_reset();
        x0 = 0; exp_pix = 0; r2pix = 0; g0p = 1'b0;
        req_x[7:0]   = 8'd0;
        req_x[23:16] = 8'd200;
        req = 4'b0001; req_plot = 4'b0101;
        pb_step();
        chk("pb_grant0", 32'(grant_o[2]), 32'b0001);
        req = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            pb_step();
            chk("pb_grant0_hold", 32'(grant_o[2]), 32'b0001);
        end
        pb_step();
        chk("pb_revoke", 32'(grant_o[2]), 0);
        chk("pb_gap_plot_next", 32'(exp_pix), 4);
        pb_step();
        chk("pb_grant2", 32'(grant_o[2]), 32'b0100);
        chk("pb_gap_plot", 32'(plot_o[2]), 0);
        pb_step();
        pb_step();
        req = 4'b0001; req_plot = 4'b0001;
        pb_step();
        chk("pb_drop_gap", 32'(grant_o[2]), 0);
        pb_step();
        chk("pb_regrant0", 32'(grant_o[2]), 32'b0001);
        for (int k = 0; k < 3; k++) pb_step();
        chk("pb_r2_pixels", 32'(r2pix), 2);
        chk("pb_no_loss", 32'(exp_pix), 32'(x0));
        chk("pb_pixels_total", 32'(exp_pix), 7);
        set_coords();

        // Asynchronous reset mid-burst.
        do_reset();
        req = 4'b0100; req_plot = 4'b0100;
        @(negedge clock);
        @(negedge clock);
        chk("ar_plot_before", 32'(plot_o[0]), 1);
        @(posedge clock); #2;
        resetn = 1'b0;
        #1;
        chk("ar_plot_now",  32'(plot_o[0]), 0);
        chk("ar_grant_now", 32'(grant_o[0]), 0);
        chk("ar_busy_now",  32'(busy_o[0]), 0);
        req = 4'b1111; req_plot = 4'b1111;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("ar_first_grant", 32'(grant_o[0]), 32'b0001);
        req = '0; req_plot = '0;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
